// File: rtl/prog_loader.sv
// Byte-stream program loader: N, then 3N data bytes MSB first, then an XOR checksum byte.
// Each 24-bit word is written once to instruction memory; a good checksum releases the processor.
module prog_loader #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   words
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  typedef enum logic [3:0] {IDLE, LEN, B2, B1, B0, WR, CHK, RUN, ERR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   addr;
  logic [ADDR_W:0]   n_words;
  logic [7:0]        csum;
  logic [WORD_W-1:0] word;
  logic              take;
  logic              start_ok;
  logic              len_bad;

  assign take      = in_valid && in_ready;
  assign start_ok  = start && (state == IDLE || state == RUN || state == ERR);
  assign len_bad   = (in_data == 8'd0) || (32'(in_data) > DEPTH);
  assign mem_addr  = addr[ADDR_W-1:0];
  assign mem_wdata = word;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    cpu_run   = 1'b0;
    err       = 1'b0;
    case (state)
      LEN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = len_bad ? ERR : B2;
      end
      B2: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = B1;
      end
      B1: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = B0;
      end
      B0: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = WR;
      end
      WR: begin
        mem_we    = 1'b1;
        busy      = 1'b1;
        state_nxt = ((words + ONE) < n_words) ? B2 : CHK;
      end
      CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = (in_data == csum) ? RUN : ERR;
      end
      RUN: begin
        cpu_run = 1'b1;
        if (start) state_nxt = LEN;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_nxt = LEN;
      end
      default: begin
        if (start) state_nxt = LEN;
      end
    endcase
  end

  // start and a byte transfer never coincide: in_ready is low wherever start is honoured.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr    <= '0;
      words   <= '0;
      n_words <= '0;
      csum    <= '0;
      word    <= '0;
    end else begin
      if (start_ok) begin
        addr  <= '0;
        words <= '0;
        csum  <= '0;
      end
      if (take && state != CHK) csum <= csum ^ in_data;
      if (take && state == LEN) n_words <= (ADDR_W+1)'(in_data);
      if (take && (state == B2 || state == B1 || state == B0))
        word <= {word[WORD_W-9:0], in_data};
      if (state == WR) begin
        addr  <= addr + ONE;
        words <= words + ONE;
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a stream-level model predicts every memory write and the session outcome.
module tb_prog_loader;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_wdata;
  logic              cpu_run;
  logic              busy;
  logic              err;
  logic [ADDR_W:0]   words;

  prog_loader #(.ADDR_W(ADDR_W), .WORD_W(24)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .busy(busy), .err(err), .words(words)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [23:0]       d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        log_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_cs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Every write the DUT makes must be the next one the model predicted.
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      check("ready_during_write", 32'(mem_we && in_ready), 32'd0);
      if (mem_we) begin
        log_q.push_back({mem_addr, mem_wdata});
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.a));
          check("wr_data", 32'(mem_wdata), 32'(e.d));
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else begin
        n++;
        if (n > 50) begin
          tests++;
          fails++;
          $display("FAIL byte_timeout: in_ready stayed 0, expected 1 for byte %0h", b);
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Model: derive expected writes and outcome from the framing rules, then drive and check.
  task automatic run_load(input string tag, input bq_t b, input bit gap);
    int         n;
    int         consumed;
    int         nw;
    bit         ok;
    logic [7:0] cs;
    n  = int'(b[0]);
    cs = b[0];
    if (n == 0 || n > DEPTH) begin
      ok       = 0;
      consumed = 1;
      nw       = 0;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({ADDR_W'(i), b[1+3*i], b[2+3*i], b[3+3*i]});
        cs = cs ^ b[1+3*i] ^ b[2+3*i] ^ b[3+3*i];
      end
      ok       = (b[3*n+1] == cs);
      consumed = 3*n + 2;
      nw       = n;
    end
    last_cs = cs;
    log_q.delete();
    pulse_start();
    for (int i = 0; i < consumed; i++) begin
      send_byte(b[i]);
      if (gap && i < consumed - 1) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    check({tag, "_words"}, 32'(words), 32'(nw));
    check({tag, "_cpu_run"}, 32'(cpu_run), 32'(ok));
    check({tag, "_err"}, 32'(err), 32'(!ok));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    check({tag, "_no_consume"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t        b;
    logic [7:0] c;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_words", 32'(words), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Two-word load with good checksum, literal pins on model and writes.
    b = '{8'h02, 8'h00, 8'h08, 8'h20, 8'h00, 8'h20, 8'h08, 8'h02};
    run_load("good2", b, 0);
    check("pin_csum", 32'(last_cs), 32'h02);
    check("pin_log_size", 32'(log_q.size()), 32'd2);
    if (log_q.size() >= 2) begin
      check("pin_w0_addr", 32'(log_q[0].a), 32'd0);
      check("pin_w0_data", 32'(log_q[0].d), 32'h000820);
      check("pin_w1_addr", 32'(log_q[1].a), 32'd1);
      check("pin_w1_data", 32'(log_q[1].d), 32'h002008);
    end
    check("good2_cpu_run_lit", 32'(cpu_run), 32'd1);

    // Same stream, bad checksum: writes still happen, session ends in error.
    b = '{8'h02, 8'h00, 8'h08, 8'h20, 8'h00, 8'h20, 8'h08, 8'h03};
    run_load("badcs", b, 0);
    check("badcs_log_size", 32'(log_q.size()), 32'd2);
    check("badcs_err_lit", 32'(err), 32'd1);

    // Length errors.
    b = '{8'h00};
    run_load("len0", b, 0);
    check("len0_no_write", 32'(log_q.size()), 32'd0);
    b = '{8'h21};
    run_load("len33", b, 0);
    check("len33_no_write", 32'(log_q.size()), 32'd0);

    // One word with in_valid toggling and start pulsed mid-session.
    b = '{8'h01, 8'hAB, 8'hCD, 8'hEF, 8'h01 ^ 8'hAB ^ 8'hCD ^ 8'hEF};
    run_load("toggle", b, 1);
    check("toggle_log_size", 32'(log_q.size()), 32'd1);
    if (log_q.size() >= 1) check("toggle_data", 32'(log_q[0].d), 32'hABCDEF);

    // Reset after the B1 byte: partial word discarded.
    log_q.delete();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_words", 32'(words), 32'd0);
    check("midrst_cpu_run", 32'(cpu_run), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_write", 32'(log_q.size()), 32'd0);
    b = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h01 ^ 8'h11 ^ 8'h22 ^ 8'h33};
    run_load("after_rst", b, 0);
    if (log_q.size() >= 1) check("after_rst_addr", 32'(log_q[0].a), 32'd0);

    // Full 32-word load.
    b.delete();
    c = 8'h20;
    b.push_back(c);
    for (int i = 0; i < DEPTH; i++) begin
      b.push_back(8'(i));
      b.push_back(8'hA5 ^ 8'(i));
      b.push_back(8'(i * 3));
      c = c ^ 8'(i) ^ (8'hA5 ^ 8'(i)) ^ 8'(i * 3);
    end
    b.push_back(c);
    run_load("full", b, 0);
    check("full_log_size", 32'(log_q.size()), 32'd32);
    if (log_q.size() == 32) check("full_last_addr", 32'(log_q[31].a), 32'h1F);
    check("full_words_lit", 32'(words), 32'h20);

    // start in RUN drops cpu_run on the next edge.
    pulse_start();
    check("rerun_cpu_run", 32'(cpu_run), 32'd0);
    check("rerun_busy", 32'(busy), 32'd1);
    check("rerun_words", 32'(words), 32'd0);
    send_byte(8'h00);
    check("rerun_err", 32'(err), 32'd1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
